// File: rtl/alu_arbiter.sv
// Round-robin arbiter that gives two requesters shared use of one external ALU.
// Each operation runs IDLE (grant) -> EXEC (capture result) -> RESP (hold until consumed).
module alu_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic [1:0] alu_ctrl,
  output logic [7:0] alu_in_1,
  output logic [7:0] alu_in_2,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last_served;
  logic       r_gnt_id;
  logic [1:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_rsp_data;
  logic       r_rsp_zero;

  logic       w_any_valid;
  logic       w_gnt_id;
  logic       w_accept;
  logic       w_rsp_hs;

  // On a tie the requester that was not served last wins; otherwise the only valid one.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_gnt_id    = (req0_valid & req1_valid) ? ~r_last_served : req1_valid;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        w_rsp_hs = r_gnt_id ? rsp1_ready : rsp0_ready;
        if (w_rsp_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: ready is combinational, so it is gated with reset to stay low while reset is held.
  assign req0_ready = w_accept & ~reset & ~w_gnt_id;
  assign req1_ready = w_accept & ~reset &  w_gnt_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_served <= 1'b1;
      r_gnt_id      <= 1'b0;
      r_op          <= 2'd0;
      r_a           <= 8'd0;
      r_b           <= 8'd0;
      r_rsp_data    <= 8'd0;
      r_rsp_zero    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_gnt_id <= w_gnt_id;
        r_op     <= w_gnt_id ? req1_op : req0_op;
        r_a      <= w_gnt_id ? req1_a  : req0_a;
        r_b      <= w_gnt_id ? req1_b  : req0_b;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data <= alu_out;
        r_rsp_zero <= alu_zero;
      end
      if (w_rsp_hs) r_last_served <= r_gnt_id;
    end
  end

  assign alu_ctrl   = r_op;
  assign alu_in_1   = r_a;
  assign alu_in_2   = r_b;
  assign rsp_data   = r_rsp_data;
  assign rsp_zero   = r_rsp_zero;
  assign rsp0_valid = (r_state == S_RESP) & ~r_gnt_id;
  assign rsp1_valid = (r_state == S_RESP) &  r_gnt_id;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written reset
// corner cases and a randomized run against a round-robin/arithmetic reference model.
module tb_alu_arbiter;

  logic       clk;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready, rsp1_ready;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic [1:0] alu_ctrl;
  logic [7:0] alu_in_1, alu_in_2;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] last_op;
  logic [7:0] last_a, last_b;

  typedef struct {
    logic       rst;
    logic       v0, v1, p0, p1;
    logic [1:0] op0;
    logic [7:0] a0, b0;
    logic [1:0] op1;
    logic [7:0] a1, b1;
    int         stall;
    logic       gnt;
    logic [7:0] data;
    logic       zero;
  } vec_t;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_ctrl(alu_ctrl), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  // 8-bit modulo ALU computed with plain integer arithmetic.
  function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int s;
    case (op)
      2'd0:    s = int'(a & b);
      2'd1:    s = int'(a | b);
      2'd2:    s = (int'(a) + int'(b)) % 256;
      default: s = (int'(a) - int'(b) + 256) % 256;
    endcase
    return 8'(s);
  endfunction

  assign alu_out  = ref_alu(alu_ctrl, alu_in_1, alu_in_2);
  assign alu_zero = (alu_out == 8'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic v0, input logic v1, input logic p0,
                              input logic p1, input logic [1:0] op0, input logic [7:0] a0,
                              input logic [7:0] b0, input logic [1:0] op1, input logic [7:0] a1,
                              input logic [7:0] b1, input int stall, input logic gnt,
                              input logic [7:0] data, input logic zero);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.p0 = p0; v.p1 = p1;
    v.op0 = op0; v.a0 = a0; v.b0 = b0; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.stall = stall; v.gnt = gnt; v.data = data; v.zero = zero;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check("ready0_during_reset", req0_ready, 0);
    check("ready1_during_reset", req1_ready, 0);
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_alu_in_1", alu_in_1, 0);
    check("rst_alu_in_2", alu_in_2, 0);
    last_op = 2'd0; last_a = 8'd0; last_b = 8'd0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1));
    #1;
    check("idle_busy", busy, 0);
    check("idle_ready0", req0_ready, 0);
    check("idle_ready1", req1_ready, 0);
    check("idle_rsp0_valid", rsp0_valid, 0);
    check("idle_rsp1_valid", rsp1_valid, 0);
    check("idle_alu_ctrl_hold", alu_ctrl, last_op);
    check("idle_alu_in_1_hold", alu_in_1, last_a);
    check("idle_alu_in_2_hold", alu_in_2, last_b);
  endtask

  // One full operation: grant cycle, one EXEC cycle, then RESP for stall+1 cycles.
  task automatic op_cycle(input vec_t v);
    logic       g;
    logic [1:0] eop;
    logic [7:0] ea, eb;
    g   = v.gnt;
    eop = g ? v.op1 : v.op0;
    ea  = g ? v.a1  : v.a0;
    eb  = g ? v.b1  : v.b0;
    @(negedge clk);
    req0_valid = v.v0; req1_valid = v.v1;
    req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
    req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check("grant_busy", busy, 0);
    check("grant_ready0", req0_ready, !g);
    check("grant_ready1", req1_ready, g);
    @(negedge clk);
    req0_valid = v.p0; req1_valid = v.p1;
    req0_op = 2'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
    req1_op = 2'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
    rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1));
    #1;
    check("exec_busy", busy, 1);
    check("exec_rsp0_valid", rsp0_valid, 0);
    check("exec_rsp1_valid", rsp1_valid, 0);
    check("exec_ready0", req0_ready, 0);
    check("exec_ready1", req1_ready, 0);
    check("exec_alu_ctrl", alu_ctrl, eop);
    check("exec_alu_in_1", alu_in_1, ea);
    check("exec_alu_in_2", alu_in_2, eb);
    for (int s = 0; s <= v.stall; s++) begin
      @(negedge clk);
      if (g) begin
        rsp1_ready = (s == v.stall); rsp0_ready = 1'($urandom_range(0, 1));
      end else begin
        rsp0_ready = (s == v.stall); rsp1_ready = 1'($urandom_range(0, 1));
      end
      #1;
      check("resp_busy", busy, 1);
      check("resp_rsp0_valid", rsp0_valid, !g);
      check("resp_rsp1_valid", rsp1_valid, g);
      check("resp_data", rsp_data, v.data);
      check("resp_zero", rsp_zero, v.zero);
      check("resp_ready0", req0_ready, 0);
      check("resp_ready1", req1_ready, 0);
    end
    last_op = eop; last_a = ea; last_b = eb;
  endtask

  vec_t tbl[12];

  initial begin
    vec_t r;
    logic last;

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 2'd0; req0_a = 8'd0; req0_b = 8'd0;
    req1_op = 2'd0; req1_a = 8'd0; req1_b = 8'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    last_op = 2'd0; last_a = 8'd0; last_b = 8'd0;

    //          rst v0 v1 p0 p1 op0   a0     b0     op1   a1     b1   stall gnt data  zero
    tbl[0]  = mk(1, 1, 1, 0, 1, 2'd3, 8'h05, 8'h05, 2'd1, 8'hF0, 8'h0F, 0, 0, 8'h00, 1);
    tbl[1]  = mk(0, 0, 1, 0, 0, 2'd0, 8'h00, 8'h00, 2'd1, 8'hF0, 8'h0F, 0, 1, 8'hFF, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 2'd2, 8'h7F, 8'h01, 2'd0, 8'h00, 8'h00, 0, 0, 8'h80, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 2'd2, 8'hFF, 8'h01, 2'd0, 8'h00, 8'h00, 0, 0, 8'h00, 1);
    tbl[4]  = mk(0, 0, 1, 0, 0, 2'd0, 8'h00, 8'h00, 2'd3, 8'h00, 8'h01, 0, 1, 8'hFF, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 2'd0, 8'hAA, 8'h55, 2'd0, 8'h00, 8'h00, 1, 0, 8'h00, 1);
    tbl[6]  = mk(0, 0, 1, 1, 0, 2'd0, 8'h00, 8'h00, 2'd1, 8'h3C, 8'hC3, 5, 1, 8'hFF, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 2'd2, 8'h10, 8'h20, 2'd0, 8'h00, 8'h00, 0, 0, 8'h30, 0);
    tbl[8]  = mk(1, 1, 1, 1, 1, 2'd2, 8'h01, 8'h02, 2'd3, 8'h10, 8'h01, 0, 0, 8'h03, 0);
    tbl[9]  = mk(0, 1, 1, 1, 1, 2'd2, 8'h01, 8'h02, 2'd3, 8'h10, 8'h01, 0, 1, 8'h0F, 0);
    tbl[10] = mk(0, 1, 1, 1, 1, 2'd0, 8'hF0, 8'h3C, 2'd1, 8'h00, 8'h00, 0, 0, 8'h30, 0);
    tbl[11] = mk(0, 1, 1, 1, 1, 2'd0, 8'hF0, 8'h3C, 2'd1, 8'h00, 8'h00, 0, 1, 8'h00, 1);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) do_reset();
      op_cycle(tbl[i]);
    end
    idle_cycle();

    // Reset pulsed during EXEC aborts the operation and restores requester-0 priority.
    do_reset();
    op_cycle(mk(0, 1, 0, 0, 0, 2'd1, 8'h01, 8'h02, 2'd0, 8'h00, 8'h00, 0, 0, 8'h03, 0));
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = 2'd2; req0_a = 8'h11; req0_b = 8'h22;
    req1_op = 2'd2; req1_a = 8'h33; req1_b = 8'h44;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check("abort_grant_ready1", req1_ready, 1);
    check("abort_grant_ready0", req0_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_exec_busy", busy, 1);
    check("abort_ready0_in_reset", req0_ready, 0);
    check("abort_ready1_in_reset", req1_ready, 0);
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rsp0_valid", rsp0_valid, 0);
    check("abort_rsp1_valid", rsp1_valid, 0);
    check("abort_rsp_data", rsp_data, 0);
    check("abort_rsp_zero", rsp_zero, 0);
    check("abort_alu_ctrl", alu_ctrl, 0);
    check("abort_alu_in_1", alu_in_1, 0);
    check("abort_alu_in_2", alu_in_2, 0);
    last_op = 2'd0; last_a = 8'd0; last_b = 8'd0;
    idle_cycle();
    op_cycle(mk(0, 1, 1, 0, 0, 2'd3, 8'h40, 8'h41, 2'd2, 8'h01, 8'h01, 0, 0, 8'hFF, 0));

    // Randomized traffic against the round-robin reference model.
    do_reset();
    last = 1'b1;
    for (int n = 0; n < 150; n++) begin
      r.rst = 1'b0;
      r.v0  = 1'($urandom_range(0, 1));
      r.v1  = 1'($urandom_range(0, 1));
      if (!r.v0 && !r.v1) begin
        idle_cycle();
      end else begin
        r.p0 = 1'($urandom_range(0, 1)); r.p1 = 1'($urandom_range(0, 1));
        r.op0 = 2'($urandom); r.a0 = 8'($urandom); r.b0 = 8'($urandom);
        r.op1 = 2'($urandom); r.a1 = 8'($urandom); r.b1 = 8'($urandom);
        r.stall = int'($urandom_range(0, 3));
        r.gnt   = (r.v0 && r.v1) ? !last : r.v1;
        r.data  = r.gnt ? ref_alu(r.op1, r.a1, r.b1) : ref_alu(r.op0, r.a0, r.b0);
        r.zero  = (r.data == 8'd0);
        op_cycle(r);
        last = r.gnt;
      end
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: none; all data paths SHALL be 8 bits and all op codes 2 bits, fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 req0_op / req1_op  input  2 each  ALU op: 0 AND, 1 OR, 2 ADD, 3 SUB.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  8 each  operands in_1, in_2.
REQ-008 rsp0_valid / rsp1_valid  output  1 each  result available for requester 0/1.
REQ-009 rsp0_ready / rsp1_ready  input  1 each  requester 0/1 consumes the result.
REQ-010 rsp_data  output  8  shared result bus.
REQ-011 rsp_zero  output  1  shared zero flag; result equals 0.
REQ-012 alu_ctrl  output  2  to shared ALU ctrl.
REQ-013 alu_in_1, alu_in_2  output  8 each  to shared ALU operands.
REQ-014 alu_out  input  8  from shared ALU result.
REQ-015 alu_zero  input  1  from shared ALU zero flag.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-018 IDLE: no valid -> stay; else grant one requester, latch its op/a/b and grant id, go EXEC.
REQ-019 Grant SHALL be round-robin: single valid -> that requester; both valid -> requester not equal to last_served.
REQ-020 reqN_ready SHALL be combinational, high only in IDLE for the granted requester in the grant cycle; never both high.
REQ-021 alu_ctrl/alu_in_1/alu_in_2 SHALL be driven from the latched registers in all states, holding values between operations.
REQ-022 EXEC: capture alu_out into rsp_data and alu_zero into rsp_zero; go RESP; EXEC lasts exactly one cycle.
REQ-023 RESP: rspN_valid SHALL be high for the granted id only; rsp_data/rsp_zero SHALL be stable while valid.
REQ-024 RESP: on rspN_ready high, set last_served to granted id, go IDLE; otherwise hold indefinitely.
REQ-025 Latency: acceptance at cycle T -> rspN_valid first high at T+2; minimum 3 cycles per operation.
REQ-026 No request SHALL be accepted in EXEC or RESP; requests waiting there stay pending, unlost.
REQ-027 Arithmetic SHALL be the ALU's 8-bit modulo result; no carry/overflow output; wrap-around passes through unchanged.
REQ-028 rspN_ready asserted outside RESP, or for the non-granted id, SHALL be ignored.
REQ-029 Request fields changing after acceptance SHALL not affect the in-flight operation.

Reset
REQ-030 reset SHALL force IDLE and last_served=1, so requester 0 wins the first tie.
REQ-031 Reset values: rsp0_valid=rsp1_valid=0, req0_ready=req1_ready=0, rsp_data=0, rsp_zero=0, alu_ctrl=0, alu_in_1=0, alu_in_2=0, busy=0.
REQ-032 Reset in EXEC or RESP SHALL abort the operation; no response SHALL be emitted for it afterward.
REQ-033 reqN_ready SHALL be 0 during any cycle with reset high.

Verification
REQ-034 req0 op=2 a=8'h7F b=8'h01 accepted at T -> rsp0_valid at T+2, rsp_data=8'h80, rsp_zero=0, rsp1_valid=0.
REQ-035 After reset, both valid same cycle: req0 op=3 a=8'h05 b=8'h05, req1 op=1 a=8'hF0 b=8'h0F -> req0 served first (8'h00, zero=1), then req1 (8'hFF, zero=0).
REQ-036 Wrap: op=2 a=8'hFF b=8'h01 -> 8'h00 zero=1; op=3 a=8'h00 b=8'h01 -> 8'hFF zero=0; op=0 a=8'hAA b=8'h55 -> 8'h00 zero=1.
REQ-037 Back-pressure: rsp1_ready low 5 cycles in RESP with req0_valid high -> rsp1_valid and rsp_data stable, req0_ready=0 throughout, req0 granted in the IDLE cycle after the handshake.
REQ-038 Both requesters continuously valid, 4 ops, immediate rsp_ready -> grant order 0,1,0,1, each op exactly 3 cycles.
REQ-039 reset pulsed one cycle while in EXEC -> next cycle all outputs at reset values, no rspN_valid, next tie granted to requester 0.
